// File: rtl/sdram_host_arbiter_pkg.sv
// Shared types for the SDRAM host-port arbiter: FSM encoding and the captured request.
package sdram_host_pkg;

  // Widths of the captured request; the arbiter ports default to these.
  localparam int SDRAM_ADDR_W = 32;
  localparam int SDRAM_DATA_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    HOLD,
    WAIT_WR,
    WAIT_RD
  } sdram_arb_state_e;

  typedef struct packed {
    logic                    we;
    logic [SDRAM_ADDR_W-1:0] addr;
    logic [SDRAM_DATA_W-1:0] wdata;
  } sdram_host_req_t;

endpackage

// File: rtl/sdram_host_arbiter_if.sv
// Requester-side and controller-side signals of the arbiter; slave = arbiter view.
interface sdram_host_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 16
);
  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0]             req_we;
  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]             req_ack;
  logic [NUM_REQ-1:0]             rsp_valid;
  logic [DATA_W-1:0]              rsp_rdata;
  logic                           rsp_err;
  logic [ADDR_W-1:0]              wr_addr;
  logic [DATA_W-1:0]              wr_data;
  logic                           wr_enable;
  logic [ADDR_W-1:0]              rd_addr;
  logic                           rd_enable;
  logic [DATA_W-1:0]              rd_data;
  logic                           rd_ready;
  logic                           busy;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rd_data, rd_ready, busy,
    output req_ack, rsp_valid, rsp_rdata, rsp_err,
           wr_addr, wr_data, wr_enable, rd_addr, rd_enable
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rd_data, rd_ready, busy,
    input  req_ack, rsp_valid, rsp_rdata, rsp_err,
           wr_addr, wr_data, wr_enable, rd_addr, rd_enable
  );
endinterface

// File: rtl/sdram_host_arbiter_rr.sv
// Combinational round-robin picker: first set request after last_grant, wrapping.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last_grant,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_idx,
  output logic                 any
);
  localparam int IW = $clog2(N);

  logic [IW-1:0] j;

  // Walk from farthest to nearest so the nearest set request is written last.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    j         = '0;
    for (int k = N; k >= 1; k--) begin
      j = IW'((int'(last_grant) + k) % N);
      if (req[j]) begin
        grant     = '0;
        grant[j]  = 1'b1;
        grant_idx = j;
        any       = 1'b1;
      end
    end
  end
endmodule

// File: rtl/sdram_host_arbiter.sv
// Shares the sdram_controller host port between NUM_REQ requesters, one word per grant,
// returning read data (or a timeout error) to the owning requester.
module sdram_host_arbiter
  import sdram_host_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_W     = SDRAM_ADDR_W,
  parameter int DATA_W     = SDRAM_DATA_W,
  parameter int HOLDOFF    = 2,
  parameter int RD_TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  sdram_host_arbiter_if.slave bus
);
  localparam int IW   = $clog2(NUM_REQ);
  localparam int TO_W = $clog2(RD_TIMEOUT + 1);
  localparam int HO_W = $clog2(HOLDOFF + 1);

  sdram_arb_state_e state, state_nxt;
  sdram_host_req_t  cur;
  logic [IW-1:0]    last_grant, owner;
  logic [HO_W-1:0]  hold_cnt;
  logic [TO_W-1:0]  to_cnt;

  logic [NUM_REQ-1:0] gnt_oh;
  logic [IW-1:0]      gnt_idx;
  logic               gnt_any;
  logic               take, hold_done, rd_window, rd_hit, rd_to;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req        (bus.req_valid),
    .last_grant (last_grant),
    .grant      (gnt_oh),
    .grant_idx  (gnt_idx),
    .any        (gnt_any)
  );

  // Ack is the only combinational output; rst gates it so all outputs read 0 in reset.
  assign take        = (state == IDLE) && !bus.busy && gnt_any && !rst;
  assign bus.req_ack = take ? gnt_oh : '0;

  assign hold_done = (hold_cnt <= HO_W'(1));
  assign rd_window = ((state == HOLD) || (state == WAIT_RD)) && !cur.we;
  assign rd_hit    = rd_window && bus.rd_ready;
  assign rd_to     = rd_window && !bus.rd_ready && (to_cnt == TO_W'(RD_TIMEOUT));

  // Addresses and write data come straight from the captured request flops.
  assign bus.wr_addr = ADDR_W'(cur.addr);
  assign bus.rd_addr = ADDR_W'(cur.addr);
  assign bus.wr_data = DATA_W'(cur.wdata);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // The holdoff window counts the ISSUE cycle, so HOLD lasts HOLDOFF-1 cycles.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (take) state_nxt = ISSUE;
      ISSUE: begin
        if (HOLDOFF > 1) state_nxt = HOLD;
        else             state_nxt = cur.we ? WAIT_WR : WAIT_RD;
      end
      HOLD: begin
        if (rd_hit || rd_to) state_nxt = IDLE;
        else if (hold_done)  state_nxt = cur.we ? WAIT_WR : WAIT_RD;
      end
      WAIT_WR: if (!bus.busy)        state_nxt = IDLE;
      WAIT_RD: if (rd_hit || rd_to)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur           <= '0;
      last_grant    <= IW'(NUM_REQ - 1);
      owner         <= '0;
      hold_cnt      <= '0;
      to_cnt        <= '0;
      bus.wr_enable <= 1'b0;
      bus.rd_enable <= 1'b0;
      bus.rsp_valid <= '0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
    end else begin
      bus.wr_enable <= 1'b0;
      bus.rd_enable <= 1'b0;
      bus.rsp_valid <= '0;
      bus.rsp_err   <= 1'b0;

      if (take) begin
        last_grant    <= gnt_idx;
        owner         <= gnt_idx;
        cur.we        <= bus.req_we[gnt_idx];
        cur.addr      <= SDRAM_ADDR_W'(bus.req_addr[gnt_idx]);
        cur.wdata     <= SDRAM_DATA_W'(bus.req_wdata[gnt_idx]);
        bus.wr_enable <= bus.req_we[gnt_idx];
        bus.rd_enable <= !bus.req_we[gnt_idx];
        to_cnt        <= TO_W'(1);
      end else if (((state == ISSUE) || (state == HOLD) || (state == WAIT_RD)) &&
                   (to_cnt != TO_W'(RD_TIMEOUT))) begin
        to_cnt <= to_cnt + TO_W'(1);
      end

      if (state == ISSUE)     hold_cnt <= HO_W'(HOLDOFF - 1);
      else if (state == HOLD) hold_cnt <= hold_cnt - HO_W'(1);

      if (rd_hit) begin
        bus.rsp_valid[owner] <= 1'b1;
        bus.rsp_rdata        <= bus.rd_data;
      end else if (rd_to) begin
        bus.rsp_valid[owner] <= 1'b1;
        bus.rsp_rdata        <= '0;
        bus.rsp_err          <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sdram_host_arbiter.sv
// Bench for sdram_host_arbiter: behavioural controller model plus a response scoreboard.
module tb_sdram_host_arbiter;
  localparam int NUM_REQ    = 4;
  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 16;
  localparam int HOLDOFF    = 2;
  localparam int RD_TIMEOUT = 16;
  localparam int BUSY_CYC   = 4;

  typedef struct {
    int               owner;
    logic [DATA_W-1:0] data;
    logic             err;
  } rsp_t;

  logic clk, rst;
  sdram_host_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  sdram_host_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .HOLDOFF(HOLDOFF), .RD_TIMEOUT(RD_TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  int cyc = 0;
  rsp_t exp_q[$];

  // controller model knobs
  bit force_busy = 0, suppress_rd = 0, no_busy = 0;
  int busy_cnt = 0;
  bit rd_pend = 0;
  logic [ADDR_W-1:0] rd_pend_addr;
  logic [DATA_W-1:0] mem [logic [ADDR_W-1:0]];

  always @(posedge clk) cyc++;

  assign bus.busy = force_busy || (busy_cnt > 0);

  always @(posedge clk) begin
    bus.rd_ready <= 1'b0;
    if (rst) begin
      busy_cnt <= 0;
      rd_pend  <= 0;
    end else if (bus.wr_enable || bus.rd_enable) begin
      if (!no_busy) busy_cnt <= BUSY_CYC;
      if (bus.wr_enable) mem[bus.wr_addr] = bus.wr_data;
      if (bus.rd_enable) begin rd_pend <= 1; rd_pend_addr <= bus.rd_addr; end
    end else if (busy_cnt > 0) begin
      busy_cnt <= busy_cnt - 1;
      if (busy_cnt == 1 && rd_pend) begin
        rd_pend <= 0;
        if (!suppress_rd) begin
          bus.rd_ready <= 1'b1;
          bus.rd_data  <= mem.exists(rd_pend_addr) ? mem[rd_pend_addr] : '0;
        end
      end
    end
  end

  // monitor: scoreboard for responses, enable overlap tracking
  bit prev_rdy = 0, armed = 0, saw_high = 0, chk_overlap = 0;
  int both_cnt = 0, ovl_cnt = 0, rsp_seen = 0, last_rsp_cyc = 0;
  always @(negedge clk) begin
    rsp_t e;
    logic [NUM_REQ-1:0] ev;
    if (rst) begin
      prev_rdy = 0; armed = 0; saw_high = 0;
    end else begin
      if (bus.wr_enable && bus.rd_enable) both_cnt++;
      if (bus.wr_enable || bus.rd_enable) begin
        if (chk_overlap && armed) ovl_cnt++;
        armed = 1; saw_high = 0;
      end else if (armed) begin
        if (bus.busy) saw_high = 1;
        else if (saw_high) armed = 0;
      end
      if (|bus.rsp_valid) begin
        rsp_seen++;
        last_rsp_cyc = cyc;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL rsp_unexpected: got rsp_valid=%b rdata=%h, wanted no response", bus.rsp_valid, bus.rsp_rdata);
        end else begin
          e  = exp_q.pop_front();
          ev = '0;
          ev[e.owner] = 1'b1;
          if ({bus.rsp_valid, bus.rsp_rdata, bus.rsp_err} !== {ev, e.data, e.err}) begin
            n_bad++;
            $display("FAIL rsp_data: got valid=%b rdata=%h err=%b, wanted valid=%b rdata=%h err=%b",
                     bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, ev, e.data, e.err);
          end
          if (!e.err) begin
            n_cmp++;
            if (prev_rdy !== 1'b1) begin
              n_bad++;
              $display("FAIL rsp_latency: rd_ready one cycle earlier was %b, wanted 1", prev_rdy);
            end
          end
        end
      end
      prev_rdy = bus.rd_ready;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, wanted completion");
    $fatal(1, "watchdog");
  end

  task automatic do_req(input int idx, input bit we, input logic [ADDR_W-1:0] addr,
                        input logic [DATA_W-1:0] wd, output bit got,
                        output logic [NUM_REQ-1:0] ackv, output int ack_cyc);
    got = 0; ackv = '0; ack_cyc = 0;
    @(posedge clk); #1;
    bus.req_we[idx] = we; bus.req_addr[idx] = addr; bus.req_wdata[idx] = wd;
    bus.req_valid[idx] = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.req_ack[idx]) begin got = 1; ackv = bus.req_ack; ack_cyc = cyc; break; end
    end
    @(posedge clk); #1;
    bus.req_valid[idx] = 1'b0;
  endtask

  task automatic drain(output bit ok);
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !bus.busy) begin ok = 1; break; end
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic reset_dut();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [127:0] outs;
    bus.req_valid = '1;
    @(negedge clk);
    outs = {bus.req_ack, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.wr_addr, bus.wr_data,
            bus.wr_enable, bus.rd_addr, bus.rd_enable};
    n_cmp++;
    if (outs !== '0) begin n_bad++; $display("FAIL reset_outputs: got %h, wanted 0", outs); end
    @(posedge clk); #1 bus.req_valid = '0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    outs = {bus.req_ack, bus.rsp_valid, bus.wr_enable, bus.rd_enable};
    n_cmp++;
    if (outs !== '0) begin n_bad++; $display("FAIL post_reset_idle: got %h, wanted 0", outs); end
  endtask

  task automatic test_single_write();
    bit got; logic [NUM_REQ-1:0] ackv; int ac;
    do_req(1, 1'b1, 32'h0, 16'h5555, got, ackv, ac);
    n_cmp++;
    if (ackv !== 4'b0010) begin n_bad++; $display("FAIL wr_ack: got %b, wanted 0010", ackv); end
    @(negedge clk);
    n_cmp++;
    if ({bus.wr_enable, bus.rd_enable, bus.wr_addr, bus.wr_data} !== {1'b1, 1'b0, 32'h0, 16'h5555}) begin
      n_bad++;
      $display("FAIL wr_issue: got we=%b re=%b addr=%h data=%h, wanted we=1 re=0 addr=0 data=5555",
               bus.wr_enable, bus.rd_enable, bus.wr_addr, bus.wr_data);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.wr_enable !== 1'b0) begin n_bad++; $display("FAIL wr_pulse_width: got %b, wanted 0", bus.wr_enable); end
    drain(got);
  endtask

  task automatic test_readback();
    bit got, ok; logic [NUM_REQ-1:0] ackv; int ac;
    exp_q.push_back('{owner: 2, data: 16'h5555, err: 1'b0});
    do_req(2, 1'b0, 32'h0, 16'h0, got, ackv, ac);
    @(negedge clk);
    n_cmp++;
    if ({bus.rd_enable, bus.wr_enable, bus.rd_addr} !== {1'b1, 1'b0, 32'h0}) begin
      n_bad++;
      $display("FAIL rd_issue: got re=%b we=%b addr=%h, wanted re=1 we=0 addr=0", bus.rd_enable, bus.wr_enable, bus.rd_addr);
    end
    drain(ok);
    n_cmp++;
    if (ok !== 1'b1) begin n_bad++; $display("FAIL rd_drain: %0d responses outstanding, wanted 0", exp_q.size()); end
  endtask

  task automatic test_fairness();
    int order[8];
    int n;
    bit ok;
    reset_dut();
    exp_q.push_back('{owner: 1, data: 16'h5555, err: 1'b0});
    exp_q.push_back('{owner: 3, data: 16'hA000, err: 1'b0});
    exp_q.push_back('{owner: 1, data: 16'h5555, err: 1'b0});
    exp_q.push_back('{owner: 3, data: 16'hA000, err: 1'b0});
    chk_overlap = 1; ovl_cnt = 0;
    @(posedge clk); #1;
    bus.req_we    = 4'b0101;
    bus.req_addr  = {32'h100, 32'h200, 32'h0, 32'h100};
    bus.req_wdata = {16'h0, 16'hA002, 16'h0, 16'hA000};
    bus.req_valid = 4'b1111;
    n = 0;
    for (int c = 0; c < 600 && n < 8; c++) begin
      @(negedge clk);
      for (int b = 0; b < NUM_REQ; b++)
        if (bus.req_ack[b]) begin order[n] = b; n++; end
    end
    @(posedge clk); #1 bus.req_valid = '0;
    n_cmp++;
    if (n !== 8) begin n_bad++; $display("FAIL fair_count: got %0d grants, wanted 8", n); end
    for (int k = 0; k < n; k++) begin
      n_cmp++;
      if (order[k] !== k % NUM_REQ) begin
        n_bad++; $display("FAIL fair_order[%0d]: got %0d, wanted %0d", k, order[k], k % NUM_REQ);
      end
    end
    drain(ok);
    chk_overlap = 0;
    n_cmp++;
    if (ovl_cnt !== 0) begin n_bad++; $display("FAIL fair_overlap: got %0d enables without busy low, wanted 0", ovl_cnt); end
    n_cmp++;
    if (ok !== 1'b1) begin n_bad++; $display("FAIL fair_drain: %0d responses outstanding, wanted 0", exp_q.size()); end
  endtask

  task automatic test_busy_block();
    int bad;
    bit ok;
    @(posedge clk); #1;
    force_busy = 1;
    bus.req_we[2] = 1'b1; bus.req_addr[2] = 32'h20; bus.req_wdata[2] = 16'h1234;
    bus.req_valid[2] = 1'b1;
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (|bus.req_ack || bus.wr_enable || bus.rd_enable) bad++;
    end
    n_cmp++;
    if (bad !== 0) begin n_bad++; $display("FAIL busy_block: got %0d active cycles while busy, wanted 0", bad); end
    @(posedge clk); #1 force_busy = 0;
    // grant lands in the first cycle busy reads low, the enable one cycle after
    @(negedge clk);
    n_cmp++;
    if (bus.req_ack !== 4'b0100) begin n_bad++; $display("FAIL busy_release_ack: got %b, wanted 0100", bus.req_ack); end
    @(posedge clk); #1 bus.req_valid[2] = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({bus.wr_enable, bus.wr_addr, bus.wr_data} !== {1'b1, 32'h20, 16'h1234}) begin
      n_bad++;
      $display("FAIL busy_release_issue: got we=%b addr=%h data=%h, wanted we=1 addr=20 data=1234",
               bus.wr_enable, bus.wr_addr, bus.wr_data);
    end
    drain(ok);
  endtask

  task automatic test_timeout();
    bit got, ok; logic [NUM_REQ-1:0] ackv; int ac, en_cyc;
    suppress_rd = 1;
    exp_q.push_back('{owner: 3, data: 16'h0, err: 1'b1});
    do_req(3, 1'b0, 32'h20, 16'h0, got, ackv, ac);
    @(negedge clk);
    en_cyc = cyc;
    n_cmp++;
    if (bus.rd_enable !== 1'b1) begin n_bad++; $display("FAIL to_issue: got rd_enable=%b, wanted 1", bus.rd_enable); end
    drain(ok);
    suppress_rd = 0;
    n_cmp++;
    if (ok !== 1'b1 || last_rsp_cyc - en_cyc !== RD_TIMEOUT) begin
      n_bad++; $display("FAIL to_latency: got %0d cycles (drained=%b), wanted %0d", last_rsp_cyc - en_cyc, ok, RD_TIMEOUT);
    end
    exp_q.push_back('{owner: 0, data: 16'h1234, err: 1'b0});
    do_req(0, 1'b0, 32'h20, 16'h0, got, ackv, ac);
    drain(ok);
    n_cmp++;
    if (ok !== 1'b1 || got !== 1'b1) begin n_bad++; $display("FAIL to_recover: got ack=%b drained=%b, wanted 1 1", got, ok); end
  endtask

  task automatic test_back_to_back();
    int ord[3], ac[3];
    int n;
    reset_dut();
    no_busy = 1;
    @(posedge clk); #1;
    bus.req_we = 4'b1001;
    bus.req_addr[0] = 32'h300; bus.req_wdata[0] = 16'h0001;
    bus.req_addr[3] = 32'h304; bus.req_wdata[3] = 16'h0002;
    bus.req_valid = 4'b1001;
    n = 0;
    for (int c = 0; c < 100 && n < 3; c++) begin
      @(negedge clk);
      for (int b = 0; b < NUM_REQ; b++)
        if (bus.req_ack[b]) begin ord[n] = b; ac[n] = cyc; n++; end
    end
    @(posedge clk); #1 bus.req_valid = '0;
    repeat (10) @(negedge clk);
    no_busy = 0;
    n_cmp++;
    if (n !== 3 || ord[0] !== 0 || ord[1] !== 3 || ord[2] !== 0) begin
      n_bad++; $display("FAIL b2b_order: got n=%0d %0d,%0d,%0d, wanted 0,3,0", n, ord[0], ord[1], ord[2]);
    end
    n_cmp++;
    if (ac[1] - ac[0] !== HOLDOFF + 2 || ac[2] - ac[1] !== HOLDOFF + 2) begin
      n_bad++; $display("FAIL b2b_spacing: got %0d,%0d cycles, wanted %0d", ac[1] - ac[0], ac[2] - ac[1], HOLDOFF + 2);
    end
  endtask

  task automatic test_reset_mid_read();
    bit got; logic [NUM_REQ-1:0] ackv; int ac, seen0;
    logic [127:0] outs;
    suppress_rd = 1;
    do_req(1, 1'b0, 32'h40, 16'h0, got, ackv, ac);
    repeat (6) @(negedge clk);
    bus.req_we[2] = 1'b1; bus.req_addr[2] = 32'h50; bus.req_wdata[2] = 16'h7777;
    bus.req_valid[2] = 1'b1;
    seen0 = rsp_seen;
    #2 rst = 1'b1;
    #1;
    outs = {bus.req_ack, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.wr_addr, bus.wr_data,
            bus.wr_enable, bus.rd_addr, bus.rd_enable};
    n_cmp++;
    if (outs !== '0) begin n_bad++; $display("FAIL mid_reset_outputs: got %h, wanted 0", outs); end
    @(posedge clk); @(posedge clk); #1;
    suppress_rd = 0;
    bus.req_we[0] = 1'b1; bus.req_addr[0] = 32'h60; bus.req_wdata[0] = 16'h8888;
    bus.req_valid = 4'b0101;
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.req_ack !== 4'b0001) begin n_bad++; $display("FAIL mid_reset_first_grant: got %b, wanted 0001", bus.req_ack); end
    @(posedge clk); #1 bus.req_valid = '0;
    repeat (30) @(negedge clk);
    n_cmp++;
    if (rsp_seen - seen0 !== 0) begin n_bad++; $display("FAIL mid_reset_no_rsp: got %0d responses, wanted 0", rsp_seen - seen0); end
  endtask

  initial begin
    rst = 1'b1;
    bus.req_valid = '0; bus.req_we = '0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.rd_ready = 1'b0; bus.rd_data = '0;
    test_reset();
    test_single_write();
    test_readback();
    test_fairness();
    test_busy_block();
    test_timeout();
    test_back_to_back();
    test_reset_mid_read();
    n_cmp++;
    if (both_cnt !== 0) begin n_bad++; $display("FAIL both_enables: got %0d cycles, wanted 0", both_cnt); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
